// File: rtl/ysyx_25040105_core_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_25040105_core_ctrl_if
//   Handshake bundle between the core sequencer and the IFU, decoder, LSU and
//   the IR/RF/PC write strobes.
//   master : sequencer side (drives reqs/strobes, samples acks/decoder flags)
//   slave  : datapath side (drives acks/decoder flags, samples reqs/strobes)
//   Signals:
//     ifu_req/ifu_ack          fetch handshake
//     ir_wen                   instruction register latch strobe
//     dec_is_load/store/ebreak decoder class flags
//     dec_reg_wen              decoder register-write enable
//     lsu_req/lsu_wen/lsu_ack  memory handshake (lsu_wen 1 = store)
//     rf_wen/pc_wen            writeback strobes
// ----------------------------------------------------------------------------
interface ysyx_25040105_core_ctrl_if;
  logic ifu_req;
  logic ifu_ack;
  logic ir_wen;
  logic dec_is_load;
  logic dec_is_store;
  logic dec_is_ebreak;
  logic dec_reg_wen;
  logic lsu_req;
  logic lsu_wen;
  logic lsu_ack;
  logic rf_wen;
  logic pc_wen;

  modport master (
    output ifu_req, ir_wen, lsu_req, lsu_wen, rf_wen, pc_wen,
    input  ifu_ack, lsu_ack, dec_is_load, dec_is_store, dec_is_ebreak, dec_reg_wen
  );

  modport slave (
    input  ifu_req, ir_wen, lsu_req, lsu_wen, rf_wen, pc_wen,
    output ifu_ack, lsu_ack, dec_is_load, dec_is_store, dec_is_ebreak, dec_reg_wen
  );
endinterface

// File: rtl/ysyx_25040105_core_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_25040105_core_ctrl
//   Multi-cycle sequencer for the NPC core:
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, HALT on ebreak.
//   Keeps a retired-instruction counter (ebreak counts as retired).
//
//   Ports:
//     clk      core clock, rising edge
//     rst      synchronous active-high reset
//     bus      handshake bundle (master modport), see the interface file
//     halt     core halted, sticky until rst
//     err      halted because a handshake timed out
//     retired  retired-instruction count, wraps silently
//     state    current FSM state (debug)
//
//   Build option:
//     CTRL_TIMEOUT_EN  when defined, a wait of TIMEOUT_CYCLES request cycles
//                      without ack sends the core to HALT with err=1 (no
//                      retire). When undefined, waits are unbounded and err=0.
// ----------------------------------------------------------------------------
module ysyx_25040105_core_ctrl #(
  parameter int CNT_W          = 32,
  parameter int RESET_DELAY    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25040105_core_ctrl_if.master   bus,
  output logic                        halt,
  output logic                        err,
  output logic [CNT_W-1:0]            retired,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int DLY_W = $clog2(RESET_DELAY + 1);

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  idle_cnt;
  logic              idle_done;
  logic              ld_q, st_q, wen_q;
  logic              wait_hit;

  assign state     = state_q;
  assign idle_done = (idle_cnt == DLY_W'(RESET_DELAY - 1));

  // ---------------------------------------------------------------- timeout
`ifdef CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            waiting;
  logic            err_q;

  // A cycle in FETCH/MEM without the matching ack counts as waiting. An ack on
  // the final allowed cycle still wins over the timeout.
  assign waiting  = ((state_q == S_FETCH) && !bus.ifu_ack) ||
                    ((state_q == S_MEM)   && !bus.lsu_ack);
  assign wait_hit = waiting && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;

  // Counter is zero whenever not waiting, so it is clear on every entry to
  // FETCH/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (wait_hit) err_q <= 1'b1;
    end
  end
`else
  assign wait_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (idle_done) state_d = S_FETCH;
      S_FETCH:  begin
        if (bus.ifu_ack)   state_d = S_DECODE;
        else if (wait_hit) state_d = S_HALT;
      end
      // ebreak is taken from the live decoder output, the same cycle it latches
      S_DECODE: state_d = bus.dec_is_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (ld_q || st_q) ? S_MEM : S_WB;
      S_MEM:    begin
        if (bus.lsu_ack)   state_d = S_WB;
        else if (wait_hit) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  // Everything is Moore except ir_wen, which follows ifu_ack in FETCH so the
  // instruction is captured in the same cycle it is presented.
  always_comb begin
    bus.ifu_req = 1'b0;
    bus.ir_wen  = 1'b0;
    bus.lsu_req = 1'b0;
    bus.lsu_wen = 1'b0;
    bus.rf_wen  = 1'b0;
    bus.pc_wen  = 1'b0;
    halt        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ifu_req = 1'b1;
        bus.ir_wen  = bus.ifu_ack;
      end
      S_MEM: begin
        bus.lsu_req = 1'b1;
        bus.lsu_wen = st_q && !ld_q;   // load wins if the decoder flags both
      end
      S_WB: begin
        bus.rf_wen  = wen_q && !st_q;
        bus.pc_wen  = 1'b1;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------- counters and dec latch
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      wen_q    <= 1'b0;
      retired  <= '0;
    end else begin
      idle_cnt <= (state_q == S_IDLE) ? idle_cnt + 1'b1 : '0;
      if (state_q == S_DECODE) begin
        ld_q  <= bus.dec_is_load;
        st_q  <= bus.dec_is_store;
        wen_q <= bus.dec_reg_wen;
      end
      // Retire on leaving WB, or on the DECODE->HALT edge for ebreak.
      if ((state_q == S_WB) || ((state_q == S_DECODE) && bus.dec_is_ebreak))
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_core_ctrl.sv
module tb_ysyx_25040105_core_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             halt, err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  int errors = 0;
  int checks = 0;

  ysyx_25040105_core_ctrl_if bus();

  ysyx_25040105_core_ctrl #(
    .CNT_W(CNT_W), .RESET_DELAY(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .halt(halt), .err(err), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_dec();
    bus.dec_is_load   = 1'b0;
    bus.dec_is_store  = 1'b0;
    bus.dec_is_ebreak = 1'b0;
    bus.dec_reg_wen   = 1'b0;
  endtask

  // Reset for 3 cycles, then walk IDLE,IDLE into FETCH.
  task automatic do_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", err, 0);
    chk("rst_ifu_req", bus.ifu_req, 0);
    chk("rst_lsu_req", bus.lsu_req, 0);
    rst = 1'b0;
    chk("idle1", state, 0);
    chk("idle1_retired", retired, 0);
    tick();
    chk("idle2", state, 0);
    chk("idle2_ifu_req", bus.ifu_req, 0);
    tick();
    chk("fetch_state", state, 1);
    chk("fetch_ifu_req", bus.ifu_req, 1);
  endtask

  // One instruction with immediate acks. Entry and exit: in FETCH, #1 after edge.
  task automatic run_inst(input bit ld, input bit st, input bit rw);
    bus.ifu_ack = 1'b1;
    #1;
    chk("ir_wen", bus.ir_wen, 1);
    tick();
    bus.ifu_ack       = 1'b0;
    bus.dec_is_load   = ld;
    bus.dec_is_store  = st;
    bus.dec_reg_wen   = rw;
    chk("decode", state, 2);
    chk("decode_ir_wen", bus.ir_wen, 0);
    tick();
    clear_dec();
    chk("exec", state, 3);
    tick();
    if (ld || st) begin
      chk("mem", state, 4);
      chk("mem_lsu_req", bus.lsu_req, 1);
      chk("mem_lsu_wen", bus.lsu_wen, {31'd0, st & ~ld});
      bus.lsu_ack = 1'b1;
      tick();
      bus.lsu_ack = 1'b0;
    end
    chk("wb", state, 5);
    chk("wb_rf_wen", bus.rf_wen, {31'd0, rw & ~st});
    chk("wb_pc_wen", bus.pc_wen, 1);
    tick();
    chk("post_wb_state", state, 1);
    chk("post_wb_pc_wen", bus.pc_wen, 0);
    chk("post_wb_rf_wen", bus.rf_wen, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    clear_dec();

    do_reset();

    // ALU, immediate ack, reg_wen=1: 4-cycle instruction
    run_inst(1'b0, 1'b0, 1'b1);
    chk("alu_retired", retired, 1);

    // Load with lsu_ack on the 4th MEM cycle
    bus.ifu_ack = 1'b1;
    tick();
    bus.ifu_ack = 1'b0;
    bus.dec_is_load = 1'b1;
    bus.dec_reg_wen = 1'b1;
    tick();
    clear_dec();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_lsu_req", bus.lsu_req, 1);
      chk("ld_wait_lsu_wen", bus.lsu_wen, 0);
      tick();
    end
    bus.lsu_ack = 1'b1;
    chk("ld_ack_lsu_req", bus.lsu_req, 1);
    tick();
    bus.lsu_ack = 1'b0;
    chk("ld_wb_state", state, 5);
    chk("ld_wb_lsu_req", bus.lsu_req, 0);
    chk("ld_wb_rf_wen", bus.rf_wen, 1);
    tick();
    chk("ld_retired", retired, 2);

    // Store with reg_wen=1: no register write
    run_inst(1'b0, 1'b1, 1'b1);
    chk("st_retired", retired, 3);

    // ALU without reg write, then a load+store (load wins)
    run_inst(1'b0, 1'b0, 1'b0);
    run_inst(1'b1, 1'b1, 1'b1);
    chk("five_retired", retired, 5);

    // ebreak: retires itself and halts
    bus.ifu_ack = 1'b1;
    tick();
    bus.ifu_ack = 1'b0;
    bus.dec_is_ebreak = 1'b1;
    tick();
    clear_dec();
    chk("halt_state", state, 6);
    chk("halt_flag", halt, 1);
    chk("halt_retired", retired, 6);
    chk("halt_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      bus.ifu_ack = 1'b1;
      bus.lsu_ack = 1'b1;
      #1;
      chk("halt_ir_wen", bus.ir_wen, 0);
      chk("halt_ifu_req", bus.ifu_req, 0);
      chk("halt_lsu_req", bus.lsu_req, 0);
      tick();
      bus.ifu_ack = 1'b0;
      bus.lsu_ack = 1'b0;
      chk("halt_stuck", state, 6);
      chk("halt_retired_stuck", retired, 6);
    end

`ifdef CTRL_TIMEOUT_EN
    // No ifu_ack: 4 request cycles, then HALT with err, nothing retired
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("to_ifu_req", bus.ifu_req, 1);
      tick();
    end
    chk("to_state", state, 6);
    chk("to_err", err, 1);
    chk("to_halt", halt, 1);
    chk("to_retired", retired, 0);
`endif

    // Wrap: 15 instructions to reach 15, 16th WB wraps the 4-bit counter
    do_reset();
    chk("wrap_err_clear", err, 0);
    for (int i = 0; i < 15; i++)
      run_inst((i % 3) == 1, (i % 3) == 2, 1'b1);
    chk("wrap_pre", retired, 15);
    run_inst(1'b0, 1'b0, 1'b1);
    chk("wrap_zero", retired, 0);

    // Reset in the middle of MEM drops lsu_req on that edge
    bus.ifu_ack = 1'b1;
    tick();
    bus.ifu_ack = 1'b0;
    bus.dec_is_store = 1'b1;
    tick();
    clear_dec();
    tick();
    chk("abort_mem", state, 4);
    rst = 1'b1;
    tick();
    chk("abort_lsu_req", bus.lsu_req, 0);
    chk("abort_state", state, 0);
    chk("abort_retired", retired, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
